// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ==== pll_reset_sequencer : PLL RESETB pulse, lock qualification and core reset (rev 1.0) ====
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_PULSE   = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_locked,
  input  logic       i_force_relock,
  output logic       o_pll_resetb,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic [1:0] o_state,
  output logic [7:0] o_loss_count,
  output logic [7:0] o_timeout_count
);

  localparam int c_CNT_W = 20;
  localparam logic [c_CNT_W-1:0] c_PULSE_LAST   = c_CNT_W'(RESET_PULSE - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  state_t                 w_nstate;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_ncnt;
  logic                   w_loss_evt;
  logic                   w_timeout_evt;
  logic                   r_pll_resetb;
  logic                   r_sys_reset;
  logic                   r_ready;
  logic [7:0]             r_loss_count;
  logic [7:0]             r_timeout_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_nstate      = r_state;
    w_ncnt        = r_cnt + c_CNT_W'(1);
    w_loss_evt    = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == c_PULSE_LAST) begin
          w_nstate = ST_WAIT_LOCK;
          w_ncnt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_nstate = ST_STABLE;
          w_ncnt   = '0;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_nstate      = ST_PLL_RST;
          w_ncnt        = '0;
          w_timeout_evt = 1'b1;
        end
      end
      ST_STABLE: begin
        // A dropout before qualification is a retry, not a loss.
        if (!w_lock_s) begin
          w_nstate = ST_WAIT_LOCK;
          w_ncnt   = '0;
        end else if (r_cnt == c_STABLE_LAST) begin
          w_nstate = ST_RUN;
          w_ncnt   = '0;
        end
      end
      ST_RUN: begin
        w_ncnt = r_cnt;
        if (!w_lock_s) begin
          w_nstate   = ST_PLL_RST;
          w_ncnt     = '0;
          w_loss_evt = 1'b1;
        end
      end
      default: begin
        w_nstate = ST_PLL_RST;
        w_ncnt   = '0;
      end
    endcase
    // Software restart wins, but the event counters above still see their cause.
    if (i_force_relock) begin
      w_nstate = ST_PLL_RST;
      w_ncnt   = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= ST_PLL_RST;
      r_cnt           <= '0;
      r_pll_resetb    <= 1'b0;
      r_sys_reset     <= 1'b1;
      r_ready         <= 1'b0;
      r_loss_count    <= '0;
      r_timeout_count <= '0;
    end else begin
      r_state      <= w_nstate;
      r_cnt        <= w_ncnt;
      r_pll_resetb <= (w_nstate != ST_PLL_RST);
      r_sys_reset  <= (w_nstate != ST_RUN);
      r_ready      <= (w_nstate == ST_RUN);
      if (w_loss_evt && (r_loss_count != 8'hFF)) begin
        r_loss_count <= r_loss_count + 8'd1;
      end
      if (w_timeout_evt && (r_timeout_count != 8'hFF)) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
    end
  end

  assign o_pll_resetb    = r_pll_resetb;
  assign o_sys_reset     = r_sys_reset;
  assign o_ready         = r_ready;
  assign o_state         = r_state;
  assign o_loss_count    = r_loss_count;
  assign o_timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ==== tb_pll_reset_sequencer : scenario bench with a phase-timing reference model (rev 1.0) ====
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int RP   = 4;
  localparam int LT   = 32;
  localparam int SC   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       force_r = 1'b0;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [7:0] loss;
  logic [7:0] tocnt;
  logic [20:0] obs;

  int checks = 0;
  int failures = 0;

  // Reference model: phase, cycles spent in phase, event tallies, lock delay line.
  int m_phase;
  int m_elapsed;
  int m_loss;
  int m_to;
  bit m_pipe [SYNC];

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .RESET_PULSE(RP), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC)
  ) u_dut (
    .i_clock(clk), .i_reset(rst), .i_locked(locked), .i_force_relock(force_r),
    .o_pll_resetb(pll_resetb), .o_sys_reset(sys_reset), .o_ready(ready),
    .o_state(state), .o_loss_count(loss), .o_timeout_count(tocnt)
  );

  assign obs = {state, pll_resetb, sys_reset, ready, loss, tocnt};

  function automatic logic [20:0] exp_vec();
    return {2'(m_phase), (m_phase != 0), (m_phase != 3), (m_phase == 3), 8'(m_loss), 8'(m_to)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_loss = 0; m_to = 0;
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    int elapsed;
    int nxt;
    ls = m_pipe[SYNC-1];
    elapsed = m_elapsed + 1;
    nxt = m_phase;
    case (m_phase)
      0: if (elapsed == RP) nxt = 1;
      1: if (ls) nxt = 2;
         else if (elapsed == LT) begin nxt = 0; if (m_to < 255) m_to++; end
      2: if (!ls) nxt = 1;
         else if (elapsed == SC) nxt = 3;
      default: if (!ls) begin nxt = 0; if (m_loss < 255) m_loss++; end
    endcase
    if (force_r) nxt = 0;
    m_elapsed = (nxt != m_phase || force_r) ? 0 : elapsed;
    m_phase = nxt;
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = locked;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; force_r = 1'b0; model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; force_r = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== {2'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
      failures++; $display("FAIL reset_state: got %h expected %h", obs, {2'd0, 1'b0, 1'b1, 1'b0, 16'd0});
    end
  endtask

  task automatic test_normal_lock();
    logic [4:0] ex;
    locked = 1'b1;
    apply_reset();
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL normal_model edge %0d: got %h expected %h", e, obs, exp_vec());
      end
      ex[4:3] = (e < 4) ? 2'd0 : (e == 4) ? 2'd1 : (e < 13) ? 2'd2 : 2'd3;
      ex[2] = (e >= 4);
      ex[1] = (e < 13);
      ex[0] = (e >= 13);
      checks++;
      if ({state, pll_resetb, sys_reset, ready} !== ex) begin
        failures++; $display("FAIL normal_timing edge %0d: got %b expected %b", e, {state, pll_resetb, sys_reset, ready}, ex);
      end
    end
  endtask

  task automatic test_timeout();
    logic [8:0] ex;
    locked = 1'b0;
    apply_reset();
    for (int e = 1; e <= 36 * 260; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL timeout_model edge %0d: got %h expected %h", e, obs, exp_vec());
      end
      ex[8] = ((e % 36) >= 4);
      ex[7:0] = (e / 36 > 255) ? 8'd255 : 8'(e / 36);
      checks++;
      if ({pll_resetb, tocnt} !== ex) begin
        failures++; $display("FAIL timeout_retry edge %0d: got %h expected %h", e, {pll_resetb, tocnt}, ex);
      end
    end
  endtask

  task automatic test_glitch();
    locked = 1'b1;
    apply_reset();
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 8) locked = 1'b0;
      if (e == 9) locked = 1'b1;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL glitch_model edge %0d: got %h expected %h", e, obs, exp_vec());
      end
      if (e == 11 || e == 19 || e == 20) begin
        checks++;
        if ({state, loss} !== {((e == 11) ? 2'd1 : (e == 19) ? 2'd2 : 2'd3), 8'd0}) begin
          failures++; $display("FAIL glitch_state edge %0d: got state=%0d loss=%0d", e, state, loss);
        end
      end
    end
  endtask

  task automatic test_loss_in_run();
    int n;
    int low;
    bit seen;
    n = 0; seen = 0;
    locked = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      tick();
      n = k;
      if (sys_reset) seen = 1;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL loss_model edge %0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    checks++;
    if (!seen || n != 3 || loss !== 8'd1) begin
      failures++; $display("FAIL loss_detect: got edges=%0d seen=%0d loss=%0d expected edges=3 loss=1", n, seen, loss);
    end
    low = (pll_resetb == 1'b0) ? 1 : 0;
    locked = 1'b1;
    for (int k = 0; k < 40 && state != 2'd3; k++) begin
      tick();
      if (!pll_resetb) low++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL relock_model cycle %0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    checks++;
    if (low != RP || state !== 2'd3) begin
      failures++; $display("FAIL relock_pulse: got low=%0d state=%0d expected low=%0d state=3", low, state, RP);
    end
  endtask

  task automatic test_simultaneous();
    int rst_cycles;
    locked = 1'b0;
    tick(); tick();
    force_r = 1'b1;
    tick();
    force_r = 1'b0;
    locked = 1'b1;
    checks++;
    if ({state, loss} !== {2'd0, 8'd2}) begin
      failures++; $display("FAIL simul_event: got state=%0d loss=%0d expected state=0 loss=2", state, loss);
    end
    rst_cycles = 1;
    for (int k = 0; k < 40 && state != 2'd3; k++) begin
      tick();
      if (state == 2'd0) rst_cycles++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL simul_model cycle %0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    checks++;
    if (rst_cycles != RP || loss !== 8'd2 || state !== 2'd3) begin
      failures++; $display("FAIL simul_single: got pllrst_cycles=%0d loss=%0d state=%0d expected %0d,2,3", rst_cycles, loss, state, RP);
    end
  endtask

  task automatic test_async_reset();
    // In RUN with a nonzero loss count.
    #2; rst = 1'b1; model_reset(); #1;
    checks++;
    if (obs !== {2'd0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      failures++; $display("FAIL async_reset_run: got %h expected %h", obs, {2'd0, 1'b0, 1'b1, 1'b0, 16'd0});
    end
    // In PLL_RST with a nonzero timeout count.
    locked = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    for (int e = 1; e <= 37; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL async_pre_model edge %0d: got %h expected %h", e, obs, exp_vec());
      end
    end
    #2; rst = 1'b1; model_reset(); #1;
    checks++;
    if (obs !== {2'd0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      failures++; $display("FAIL async_reset_pllrst: got %h expected %h", obs, {2'd0, 1'b0, 1'b1, 1'b0, 16'd0});
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (pll_resetb !== (e >= RP) || obs !== exp_vec()) begin
        failures++; $display("FAIL async_restart edge %0d: got %h expected %h", e, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    locked = 1'b0;
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        locked = ~locked;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 60));
      end
      hold--;
      force_r = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL random_model cycle %0d: got %h expected %h", k, obs, exp_vec());
      end
    end
    force_r = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal_lock();
    test_timeout();
    test_glitch();
    test_loss_in_run();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
